mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 155 +++++++++++++++
 tb/tb_mem_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, doubleword data memory with range checking,
// branch resolution, and the MEM/WB register that feeds writeback.
module mem_stage #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] ALUResult,
    input  logic [63:0] PCPlusImmShifted,
    input  logic        Zero,
    input  logic [63:0] forwardedData2,
    input  logic [4:0]  rd_addr,
    input  logic        RegWrite,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        Branch,
    input  logic        MemtoReg,
    input  logic        flush,
    output logic [63:0] EX_MEM_ALUResult,
    output logic        EX_MEM_RegWrite,
    output logic [4:0]  EX_MEM_rd_addr,
    output logic        PCSrc,
    output logic [63:0] branch_target,
    output logic [63:0] MEM_WB_ALUResult,
    output logic [63:0] MEM_WB_mem_readData,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_memRead,
    output logic        MEM_WB_MemtoReg,
    output logic [4:0]  MEM_WB_rd_addr,
    output logic [63:0] WB_writeData,
    output logic        mem_fault
);

    localparam int AW = $clog2(DEPTH);

    logic [63:0]   ex_alu_r;
    logic [63:0]   ex_pc_r;
    logic [63:0]   ex_store_r;
    logic          ex_zero_r;
    logic [4:0]    ex_rd_r;
    logic          ex_regwrite_r;
    logic          ex_memread_r;
    logic          ex_memwrite_r;
    logic          ex_branch_r;
    logic          ex_memtoreg_r;

    logic [63:0]   wb_alu_r;
    logic [63:0]   wb_rdata_r;
    logic          wb_regwrite_r;
    logic          wb_memread_r;
    logic          wb_memtoreg_r;
    logic [4:0]    wb_rd_r;
    logic          fault_r;

    logic [63:0]   mem_r [DEPTH];

    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic          wr_en_s;
    logic          fault_evt_s;
    logic [63:0]   rd_data_s;

    // Byte offset bits [2:0] are ignored; anything above the index field is out of range.
    assign idx_s       = ex_alu_r[2+AW:3];
    assign oor_s       = |ex_alu_r[63:3+AW];
    assign wr_en_s     = ex_memwrite_r && !oor_s;
    assign fault_evt_s = (ex_memwrite_r || ex_memread_r) && oor_s;

    // Combinational memory read; a simultaneous read+write is treated as write-only.
    always_comb begin
        rd_data_s = 64'd0;
        if (ex_memread_r && !ex_memwrite_r && !oor_s) begin
            rd_data_s = mem_r[idx_s];
        end else begin
            rd_data_s = 64'd0;
        end
    end

    // EX/MEM register; flush kills the control bits but data fields still capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_alu_r      <= 64'd0;
            ex_pc_r       <= 64'd0;
            ex_store_r    <= 64'd0;
            ex_zero_r     <= 1'b0;
            ex_rd_r       <= 5'd0;
            ex_regwrite_r <= 1'b0;
            ex_memread_r  <= 1'b0;
            ex_memwrite_r <= 1'b0;
            ex_branch_r   <= 1'b0;
            ex_memtoreg_r <= 1'b0;
        end else begin
            ex_alu_r      <= ALUResult;
            ex_pc_r       <= PCPlusImmShifted;
            ex_store_r    <= forwardedData2;
            ex_zero_r     <= Zero;
            ex_rd_r       <= rd_addr;
            ex_memtoreg_r <= MemtoReg;
            if (flush) begin
                ex_regwrite_r <= 1'b0;
                ex_memread_r  <= 1'b0;
                ex_memwrite_r <= 1'b0;
                ex_branch_r   <= 1'b0;
            end else begin
                ex_regwrite_r <= RegWrite;
                ex_memread_r  <= MemRead;
                ex_memwrite_r <= MemWrite;
                ex_branch_r   <= Branch;
            end
        end
    end

    // MEM/WB register and the sticky out-of-range fault flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_alu_r      <= 64'd0;
            wb_rdata_r    <= 64'd0;
            wb_regwrite_r <= 1'b0;
            wb_memread_r  <= 1'b0;
            wb_memtoreg_r <= 1'b0;
            wb_rd_r       <= 5'd0;
            fault_r       <= 1'b0;
        end else begin
            wb_alu_r      <= ex_alu_r;
            wb_rdata_r    <= rd_data_s;
            wb_regwrite_r <= ex_regwrite_r;
            wb_memread_r  <= ex_memread_r;
            wb_memtoreg_r <= ex_memtoreg_r;
            wb_rd_r       <= ex_rd_r;
            fault_r       <= fault_r || fault_evt_s;
        end
    end

    // Data memory array is deliberately not reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (reset && wr_en_s) begin
            mem_r[idx_s] <= ex_store_r;
        end
    end

    assign EX_MEM_ALUResult    = ex_alu_r;
    assign EX_MEM_RegWrite     = ex_regwrite_r;
    assign EX_MEM_rd_addr      = ex_rd_r;
    assign PCSrc               = ex_branch_r & ex_zero_r;
    assign branch_target       = ex_pc_r;
    assign MEM_WB_ALUResult    = wb_alu_r;
    assign MEM_WB_mem_readData = wb_rdata_r;
    assign MEM_WB_RegWrite     = wb_regwrite_r;
    assign MEM_WB_memRead      = wb_memread_r;
    assign MEM_WB_MemtoReg     = wb_memtoreg_r;
    assign MEM_WB_rd_addr      = wb_rd_r;
    assign WB_writeData        = wb_memtoreg_r ? wb_rdata_r : wb_alu_r;
    assign mem_fault           = fault_r;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_mem_stage;

    localparam int DEPTH = 128;

    logic        clk;
    logic        reset;
    logic [63:0] ALUResult, PCPlusImmShifted, forwardedData2;
    logic        Zero, RegWrite, MemRead, MemWrite, Branch, MemtoReg, flush;
    logic [4:0]  rd_addr;
    logic [63:0] EX_MEM_ALUResult, branch_target, MEM_WB_ALUResult, MEM_WB_mem_readData, WB_writeData;
    logic        EX_MEM_RegWrite, PCSrc, MEM_WB_RegWrite, MEM_WB_memRead, MEM_WB_MemtoReg, mem_fault;
    logic [4:0]  EX_MEM_rd_addr, MEM_WB_rd_addr;

    mem_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ALUResult(ALUResult), .PCPlusImmShifted(PCPlusImmShifted), .Zero(Zero),
        .forwardedData2(forwardedData2), .rd_addr(rd_addr),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch),
        .MemtoReg(MemtoReg), .flush(flush),
        .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_rd_addr(EX_MEM_rd_addr), .PCSrc(PCSrc), .branch_target(branch_target),
        .MEM_WB_ALUResult(MEM_WB_ALUResult), .MEM_WB_mem_readData(MEM_WB_mem_readData),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_memRead(MEM_WB_memRead),
        .MEM_WB_MemtoReg(MEM_WB_MemtoReg), .MEM_WB_rd_addr(MEM_WB_rd_addr),
        .WB_writeData(WB_writeData), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One instruction as it sits after the execute stage.
    typedef struct {
        logic [63:0] alu, pc, st;
        logic        zero, rw, mr, mw, br, m2r;
        logic [4:0]  rd;
    } instr_t;

    // One instruction as it leaves the memory stage.
    typedef struct {
        logic [63:0] alu, rdata;
        logic        rw, mr, m2r;
        logic [4:0]  rd;
    } retire_t;

    instr_t      m_ex;
    retire_t     m_wb;
    logic        m_fault;
    logic [63:0] m_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic instr_t blank();
        instr_t t;
        t = '{alu: 64'd0, pc: 64'd0, st: 64'd0, zero: 1'b0, rw: 1'b0, mr: 1'b0,
              mw: 1'b0, br: 1'b0, m2r: 1'b0, rd: 5'd0};
        return t;
    endfunction

    task automatic model_reset();
        m_ex    = blank();
        m_wb    = '{alu: 64'd0, rdata: 64'd0, rw: 1'b0, mr: 1'b0, m2r: 1'b0, rd: 5'd0};
        m_fault = 1'b0;
    endtask

    // Advance the model by one clock: retire the memory-stage instruction, accept a new one.
    task automatic model_edge();
        logic        in_rng;
        logic [63:0] rdat;
        int          w;
        in_rng = (m_ex.alu < 64'(DEPTH) * 64'd8);
        w      = int'(m_ex.alu / 64'd8);
        rdat   = 64'd0;
        if (m_ex.mr && !m_ex.mw && in_rng) rdat = m_mem[w];
        if ((m_ex.mr || m_ex.mw) && !in_rng) m_fault = 1'b1;
        if (m_ex.mw && in_rng) m_mem[w] = m_ex.st;
        m_wb = '{alu: m_ex.alu, rdata: rdat, rw: m_ex.rw, mr: m_ex.mr, m2r: m_ex.m2r, rd: m_ex.rd};
        m_ex = '{alu: ALUResult, pc: PCPlusImmShifted, st: forwardedData2, zero: Zero,
                 rw: RegWrite && !flush, mr: MemRead && !flush, mw: MemWrite && !flush,
                 br: Branch && !flush, m2r: MemtoReg, rd: rd_addr};
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":ex_alu"},   EX_MEM_ALUResult, m_ex.alu);
        chk({ph, ":ex_rw"},    64'(EX_MEM_RegWrite), 64'(m_ex.rw));
        chk({ph, ":ex_rd"},    64'(EX_MEM_rd_addr), 64'(m_ex.rd));
        chk({ph, ":pcsrc"},    64'(PCSrc), 64'(m_ex.br && m_ex.zero));
        chk({ph, ":btarget"},  branch_target, m_ex.pc);
        chk({ph, ":wb_alu"},   MEM_WB_ALUResult, m_wb.alu);
        chk({ph, ":wb_rdata"}, MEM_WB_mem_readData, m_wb.rdata);
        chk({ph, ":wb_rw"},    64'(MEM_WB_RegWrite), 64'(m_wb.rw));
        chk({ph, ":wb_mr"},    64'(MEM_WB_memRead), 64'(m_wb.mr));
        chk({ph, ":wb_m2r"},   64'(MEM_WB_MemtoReg), 64'(m_wb.m2r));
        chk({ph, ":wb_rd"},    64'(MEM_WB_rd_addr), 64'(m_wb.rd));
        chk({ph, ":wb_data"},  WB_writeData, m_wb.m2r ? m_wb.rdata : m_wb.alu);
        chk({ph, ":fault"},    64'(mem_fault), 64'(m_fault));
    endtask

    task automatic drive(input logic [63:0] alu, input logic [63:0] pc, input logic [63:0] st,
                         input logic zero, input logic rw, input logic mr, input logic mw,
                         input logic br, input logic m2r, input logic fl, input logic [4:0] rd);
        ALUResult = alu; PCPlusImmShifted = pc; forwardedData2 = st; Zero = zero;
        RegWrite = rw; MemRead = mr; MemWrite = mw; Branch = br; MemtoReg = m2r;
        flush = fl; rd_addr = rd;
    endtask

    task automatic nop();
        drive(64'd0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_all(ph);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] old40, word0;
        nop();
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 64'd0;
        #13;
        check_all("reset");
        reset = 1'b1;

        // Fill every doubleword so later reads are well defined.
        for (int i = 0; i < DEPTH; i++) begin
            drive(64'(i) * 64'd8 + 64'($urandom_range(0, 7)), 64'd0, {$urandom, $urandom},
                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
            step("fill");
        end
        nop();
        step("fill_end");

        // Forwarding timing.
        drive(64'd7, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5);
        step("fwd1");
        chk("fwd_ex_rd", 64'(EX_MEM_rd_addr), 64'd5);
        chk("fwd_ex_alu", EX_MEM_ALUResult, 64'd7);
        nop();
        step("fwd2");
        chk("fwd_wb_alu", MEM_WB_ALUResult, 64'd7);
        chk("fwd_wb_rw", 64'(MEM_WB_RegWrite), 64'd1);

        // Store then immediately load the same doubleword.
        drive(64'h40, 64'd0, 64'hDEADBEEF_01234567, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step("st");
        drive(64'h40, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd3);
        step("ld");
        nop();
        step("ld_wb");
        chk("stld_rdata", MEM_WB_mem_readData, 64'hDEADBEEF_01234567);
        chk("stld_wbdata", WB_writeData, 64'hDEADBEEF_01234567);

        // Byte-offset aliasing.
        drive(64'h47, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd4);
        step("alias");
        nop();
        step("alias_wb");
        chk("alias_rdata", MEM_WB_mem_readData, 64'hDEADBEEF_01234567);

        // Read and write together behave as a write only.
        drive(64'h48, 64'd0, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        step("rw1");
        nop();
        step("rw2");
        chk("rw_rdata", MEM_WB_mem_readData, 64'd0);

        // Branch taken, then the same branch flushed.
        drive(64'd0, 64'h1000, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        step("br");
        chk("br_pcsrc", 64'(PCSrc), 64'd1);
        chk("br_target", branch_target, 64'h1000);
        drive(64'd0, 64'h1000, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd0);
        step("brfl");
        chk("brfl_pcsrc", 64'(PCSrc), 64'd0);

        // Randomized in-range traffic.
        for (int n = 0; n < 300; n++) begin
            drive(64'($urandom_range(0, DEPTH * 8 - 1)), {$urandom, $urandom}, {$urandom, $urandom},
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 7) == 0), 5'($urandom));
            step("rand");
        end
        nop();
        step("rand_end");

        // Reset between edges while a store is held in EX/MEM.
        old40 = m_mem[8];
        drive(64'h40, 64'd0, 64'hCAFE_F00D_0000_0001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9);
        step("pre_rst");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        chk("rst_ex_alu", EX_MEM_ALUResult, 64'd0);
        step("rst_held");
        reset = 1'b1;
        drive(64'h40, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2);
        step("post_ld");
        nop();
        step("post_wb");
        chk("rst_abort_rdata", MEM_WB_mem_readData, old40);

        // Out-of-range store: fault set, aliased word untouched, flag sticky.
        word0 = m_mem[0];
        drive(64'h10000, 64'd0, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        step("oor1");
        nop();
        step("oor2");
        chk("oor_fault", 64'(mem_fault), 64'd1);
        drive(64'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step("oor_ld");
        nop();
        for (int k = 0; k < 4; k++) step("oor_hold");
        chk("oor_mem", MEM_WB_ALUResult, 64'd0);
        chk("oor_sticky", 64'(mem_fault), 64'd1);
        drive(64'h0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step("oor_ld2");
        nop();
        step("oor_ld2_wb");
        chk("oor_word0", MEM_WB_mem_readData, word0);
        reset = 1'b0;
        model_reset();
        #1;
        chk("fault_clr", 64'(mem_fault), 64'd0);
        reset = 1'b1;
        step("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
